// File: rtl/uart_rx.sv
// 8N1 UART receiver with a two-flop input synchronizer and a valid/ready byte output.
// A byte that arrives while the previous one is still unaccepted is dropped and flagged with oOVR.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       iCLK_50,
  input  logic       iRST_N,
  input  logic       iUART_RXD,
  input  logic       iREADY,
  output logic [7:0] oDATA,
  output logic       oVALID,
  output logic       oFERR,
  output logic       oOVR,
  output logic       oBUSY
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_IDLE = 3'd4;

  logic             rxMeta;
  logic             rxs;
  logic [2:0]       state;
  logic [CNT_W-1:0] bitCnt;
  logic [2:0]       bitIdx;
  logic [7:0]       shiftReg;

  // NOTE: the synchronizer resets to 1 (idle line) so reset release never looks like a start bit.
  always_ff @(posedge iCLK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      rxMeta <= 1'b1;
      rxs    <= 1'b1;
    end else begin
      rxMeta <= iUART_RXD;
      rxs    <= rxMeta;
    end
  end

  // NOTE: all state uses non-blocking assignments; later assignments in this block
  // deliberately override the defaults at its top (e.g. a delivery re-sets oVALID).
  always_ff @(posedge iCLK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      state    <= IDLE;
      bitCnt   <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
      oDATA    <= '0;
      oVALID   <= 1'b0;
      oFERR    <= 1'b0;
      oOVR     <= 1'b0;
    end else begin
      oFERR <= 1'b0;
      oOVR  <= 1'b0;
      if (oVALID && iREADY) begin
        oVALID <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!rxs) begin
            state  <= START;
            bitCnt <= '0;
          end
        end

        START: begin
          if (bitCnt == HALF_BIT) begin
            bitCnt <= '0;
            bitIdx <= '0;
            state  <= rxs ? IDLE : DATA;
          end else begin
            bitCnt <= bitCnt + CNT_ONE;
          end
        end

        DATA: begin
          if (bitCnt == FULL_BIT) begin
            shiftReg[bitIdx] <= rxs;
            bitCnt           <= '0;
            bitIdx           <= bitIdx + 3'd1;
            if (bitIdx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            bitCnt <= bitCnt + CNT_ONE;
          end
        end

        STOP: begin
          if (bitCnt == FULL_BIT) begin
            bitCnt <= '0;
            if (rxs) begin
              state <= IDLE;
              // Held byte still pending and not taken this cycle: drop the new one.
              if (oVALID && !iREADY) begin
                oOVR <= 1'b1;
              end else begin
                oDATA  <= shiftReg;
                oVALID <= 1'b1;
              end
            end else begin
              oFERR <= 1'b1;
              state <= WAIT_IDLE;
            end
          end else begin
            bitCnt <= bitCnt + CNT_ONE;
          end
        end

        WAIT_IDLE: begin
          if (rxs) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign oBUSY = (state != IDLE);

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, meaning iCLK_50 cycles per serial bit (50 MHz / 115200 baud); legal range 8..65535.
REQ-002 iCLK_50  input  1  system clock; all state updates on its rising edge.
REQ-003 iRST_N  input  1  reset, asynchronous, active-low.
REQ-004 iUART_RXD  input  1  serial line, 8N1 format, LSB first, idle high; asynchronous to iCLK_50.
REQ-005 iREADY  input  1  consumer accepts the held byte in any cycle where oVALID and iREADY are both high.
REQ-006 oDATA  output  8  last received byte; stable while oVALID is high.
REQ-007 oVALID  output  1  a received byte is held and not yet accepted.
REQ-008 oFERR  output  1  one-cycle pulse on a framing error.
REQ-009 oOVR  output  1  one-cycle pulse on an overrun.
REQ-010 oBUSY  output  1  high in every state except IDLE.

Function
REQ-011 iUART_RXD SHALL pass through a 2-flop synchronizer whose flops reset to 1; all logic uses only the synchronized signal (rxs).
REQ-012 The FSM SHALL have states IDLE, START, DATA, STOP and WAIT_IDLE, plus a bit-period counter of width ceil(log2(CLKS_PER_BIT)) and a 3-bit bit index.
REQ-013 IDLE: on rxs==0, go to START and clear the counter.
REQ-014 START: at counter == CLKS_PER_BIT/2-1 (integer divide), sample rxs; 0 -> go to DATA with counter and bit index cleared; 1 -> treat as a glitch and go to IDLE with no output.
REQ-015 DATA: at counter == CLKS_PER_BIT-1, shift rxs into bit[index] (LSB first) and clear the counter; after index 7 go to STOP.
REQ-016 STOP: at counter == CLKS_PER_BIT-1, sample rxs; 1 -> deliver the byte and go to IDLE; 0 -> pulse oFERR, discard the byte, go to WAIT_IDLE.
REQ-017 WAIT_IDLE: stay until rxs==1, then go to IDLE; no start detection occurs in this state.
REQ-018 Delivery with oVALID low, or with oVALID and iREADY both high in the same cycle: load oDATA and set oVALID on the cycle after the stop-bit sample.
REQ-019 Delivery with oVALID high and iREADY low: discard the new byte, keep oDATA unchanged, and pulse oOVR for one cycle.
REQ-020 oVALID SHALL clear on the cycle after an oVALID&iREADY handshake, unless REQ-018 reloads it in that same cycle.
REQ-021 oFERR and oOVR SHALL never be high for more than one consecutive cycle per event.
REQ-022 Reception SHALL continue regardless of oVALID and iREADY; the FSM is never stalled by the consumer.

Reset
REQ-023 While iRST_N==0, these SHALL hold asynchronously: FSM=IDLE, counter=0, index=0, shift register=0x00, oDATA=0x00, oVALID=0, oFERR=0, oOVR=0, oBUSY=0, synchronizer flops=1.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no delivery and no error pulse.
REQ-025 After reset release, the first falling edge on rxs starts a new frame.

Verification (bench uses CLKS_PER_BIT=16 and a 160-cycle frame)
REQ-026 Send 0x55 with iREADY=0 -> oVALID=1 and oDATA=0x55, held; pulse iREADY for 1 cycle -> oVALID=0 on the next cycle.
REQ-027 Drive iUART_RXD low for 5 cycles, then high -> oVALID, oFERR and oOVR all stay 0; oBUSY returns to 0 once the START check fails.
REQ-028 Send 0xA3 with stop bit = 0, then hold the line low for 40 cycles -> one oFERR pulse, oVALID stays 0, oBUSY stays 1 until the line returns high.
REQ-029 Send 0x12 and 0x34 back to back with iREADY=0 -> oDATA=0x12, one oOVR pulse at the second stop sample; then iREADY=1 -> oVALID=0.
REQ-030 Hold iREADY=1 and send 0x12 then 0x34 -> two single-cycle oVALID assertions with oDATA 0x12 then 0x34, and no oOVR.
REQ-031 Assert iRST_N=0 during data bit 4 of 0xF0, release, then send 0xC9 -> all outputs 0 during reset; exactly one delivery afterwards, with oDATA=0xC9.
